// File: rtl/axi_tmr_arb_pkg.sv
// Shared types and helpers for the TMR address arbiters.
//   arb_state_e   : arbiter FSM state (idle / holding a grant)
//   maj3          : bitwise 2-of-3 majority over up to MAX_REQ bits
//   onehot_to_idx : binary index of the set bit in a one-hot vector
package axi_tmr_arb_pkg;

    // Widest requester vector the helpers are sized for.
    localparam int MAX_REQ = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Bitwise majority of three replicas; narrower callers zero-extend.
    function automatic logic [MAX_REQ-1:0] maj3(
        input logic [MAX_REQ-1:0] a,
        input logic [MAX_REQ-1:0] b,
        input logic [MAX_REQ-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    // OR-reduction of the indices of set bits; exact for one-hot input,
    // 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = idx | (oh[i] ? unsigned'(i) : 32'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_tmr_rr_select.sv
// Combinational round-robin selector.
//   req      : request vector
//   last_idx : most recently served index; search starts at last_idx+1
//   grant    : one-hot winner (all zero when nothing is requested)
//   valid    : any request present
module axi_tmr_rr_select #(
    parameter int S_COUNT = 4,
    parameter int IDX_W   = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [S_COUNT-1:0] grant,
    output logic               valid
);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Walk the requesters in pointer order and keep only the first hit.
    always_comb begin
        grant   = {S_COUNT{1'b0}};
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        for (int k = 1; k <= S_COUNT; k++) begin
            idx_s        = IDX_W'((int'(last_idx) + k) % S_COUNT);
            grant[idx_s] = req[idx_s] & ~found_s;
            found_s      = found_s | req[idx_s];
        end
        valid = found_s;
    end

endmodule

// File: rtl/axi_tmr_simple_voter.sv
// Generic bitwise TMR voter.
//   in0/in1/in2 : the three replicas (WIDTH bits each, WIDTH <= MAX_REQ)
//   voted       : 2-of-3 majority per bit
//   mismatch    : high when any bit differs between the replicas
module axi_tmr_simple_voter
    import axi_tmr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);

    assign voted    = WIDTH'(maj3(MAX_REQ'(in0), MAX_REQ'(in1), MAX_REQ'(in2)));
    assign mismatch = |((in0 ^ in1) | (in0 ^ in2));

endmodule

// File: rtl/axi_tmr_addr_arbiter.sv
// Round-robin arbiter sharing one master address channel between S_COUNT
// TMR slave-side address units.
//   clk, rst     : clock, synchronous active-high reset
//   s_req_tmr0-2 : triplicated per-requester address valid
//   s_ready      : one-hot ready, high only in the handshake cycle
//   m_grant      : registered one-hot grant, m_grant_idx its index
//   m_valid      : address valid toward the master, m_ready its accept
//   err_clear    : clears the replica-disagreement monitors
//   err_mismatch : sticky disagreement flag, err_count saturating count
module axi_tmr_addr_arbiter
    import axi_tmr_arb_pkg::*;
#(
    parameter  int S_COUNT   = 4,
    parameter  int CNT_WIDTH = 16,
    localparam int IDX_W     = $clog2(S_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_COUNT-1:0]   s_req_tmr0,
    input  logic [S_COUNT-1:0]   s_req_tmr1,
    input  logic [S_COUNT-1:0]   s_req_tmr2,
    output logic [S_COUNT-1:0]   s_ready,
    output logic [S_COUNT-1:0]   m_grant,
    output logic [IDX_W-1:0]     m_grant_idx,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 err_clear,
    output logic                 err_mismatch,
    output logic [CNT_WIDTH-1:0] err_count
);

    logic [S_COUNT-1:0]   req_s;
    logic                 mismatch_s;
    logic [S_COUNT-1:0]   sel_grant_s;
    logic                 sel_valid_s;
    logic [IDX_W-1:0]     sel_last_s;
    logic                 handshake_s;

    arb_state_e           state_r;
    logic [S_COUNT-1:0]   m_grant_r;
    logic [IDX_W-1:0]     m_grant_idx_r;
    logic [IDX_W-1:0]     last_idx_r;
    logic                 err_mismatch_r;
    logic [CNT_WIDTH-1:0] err_count_r;

    axi_tmr_simple_voter #(
        .WIDTH (S_COUNT)
    ) u_req_voter (
        .in0      (s_req_tmr0),
        .in1      (s_req_tmr1),
        .in2      (s_req_tmr2),
        .voted    (req_s),
        .mismatch (mismatch_s)
    );

    // While busy the current holder is masked out and the pointer is the
    // holder itself, so a handshake re-arbitrates among the others only.
    // In idle the grant is zero and the stored pointer is used.
    assign sel_last_s = (state_r == ST_BUSY) ? m_grant_idx_r : last_idx_r;

    axi_tmr_rr_select #(
        .S_COUNT (S_COUNT),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req      (req_s & ~m_grant_r),
        .last_idx (sel_last_s),
        .grant    (sel_grant_s),
        .valid    (sel_valid_s)
    );

    // Valid follows the voted request of the holder, so a dropped request
    // never presents a stale address.
    assign m_valid     = (state_r == ST_BUSY) & (|(req_s & m_grant_r));
    // Reset suppresses the handshake so a reset mid-grant never pulses ready.
    assign handshake_s = m_valid & m_ready & ~rst;
    assign s_ready     = handshake_s ? m_grant_r : {S_COUNT{1'b0}};
    assign m_grant     = m_grant_r;
    assign m_grant_idx = m_grant_idx_r;

    // Arbitration FSM: grant registration, hold, release and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            m_grant_r     <= {S_COUNT{1'b0}};
            m_grant_idx_r <= {IDX_W{1'b0}};
            last_idx_r    <= IDX_W'(S_COUNT - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s) begin
                        m_grant_r     <= sel_grant_s;
                        m_grant_idx_r <= IDX_W'(onehot_to_idx(MAX_REQ'(sel_grant_s)));
                        state_r       <= ST_BUSY;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (handshake_s) begin
                        last_idx_r <= m_grant_idx_r;
                        if (sel_valid_s) begin
                            m_grant_r     <= sel_grant_s;
                            m_grant_idx_r <= IDX_W'(onehot_to_idx(MAX_REQ'(sel_grant_s)));
                            state_r       <= ST_BUSY;
                        end else begin
                            m_grant_r     <= {S_COUNT{1'b0}};
                            m_grant_idx_r <= {IDX_W{1'b0}};
                            state_r       <= ST_IDLE;
                        end
                    end else if (!m_valid) begin
                        // Holder lost its voted request: release, keep pointer.
                        m_grant_r     <= {S_COUNT{1'b0}};
                        m_grant_idx_r <= {IDX_W{1'b0}};
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_BUSY;
                    end
                end
                default: begin
                    m_grant_r     <= {S_COUNT{1'b0}};
                    m_grant_idx_r <= {IDX_W{1'b0}};
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    // Replica disagreement monitor; a clear coinciding with a mismatch
    // restarts the count at one so the event is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_mismatch_r <= 1'b0;
            err_count_r    <= {CNT_WIDTH{1'b0}};
        end else if (err_clear) begin
            err_mismatch_r <= mismatch_s;
            err_count_r    <= mismatch_s ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : {CNT_WIDTH{1'b0}};
        end else if (mismatch_s) begin
            err_mismatch_r <= 1'b1;
            err_count_r    <= (err_count_r == {CNT_WIDTH{1'b1}}) ? err_count_r
                                                               : err_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            err_mismatch_r <= err_mismatch_r;
            err_count_r    <= err_count_r;
        end
    end

    assign err_mismatch = err_mismatch_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_axi_tmr_addr_arbiter.sv
module tb_axi_tmr_addr_arbiter;

    localparam int S  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [S-1:0]  r0, r1, r2;
    logic [S-1:0]  s_ready, m_grant;
    logic [1:0]    m_grant_idx;
    logic          m_valid, m_ready, err_clear, err_mismatch;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit mb;      // a grant is held
    int mg;      // granted index
    int ml;      // last served index
    int mc;      // mismatch count
    bit ms;      // sticky mismatch

    always #5 clk = ~clk;

    axi_tmr_addr_arbiter #(.S_COUNT(S), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_req_tmr0(r0), .s_req_tmr1(r1), .s_req_tmr2(r2),
        .s_ready(s_ready), .m_grant(m_grant), .m_grant_idx(m_grant_idx),
        .m_valid(m_valid), .m_ready(m_ready), .err_clear(err_clear),
        .err_mismatch(err_mismatch), .err_count(err_count)
    );

    function automatic logic [S-1:0] vote(logic [S-1:0] a, logic [S-1:0] b, logic [S-1:0] c);
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) begin
            v[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
        end
        return v;
    endfunction

    function automatic bit disagree(logic [S-1:0] a, logic [S-1:0] b, logic [S-1:0] c);
        bit d = 0;
        for (int i = 0; i < S; i++) begin
            int n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            if (n == 1 || n == 2) d = 1;
        end
        return d;
    endfunction

    function automatic int pick(logic [S-1:0] rq, int from);
        for (int k = 1; k <= S; k++) begin
            int i = (from + k) % S;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb = 0; mg = 0; ml = S - 1; mc = 0; ms = 0;
    endtask

    task automatic set_req(logic [S-1:0] a, logic [S-1:0] b, logic [S-1:0] c);
        r0 = a; r1 = b; r2 = c;
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic cycle();
        logic [S-1:0] rq;
        bit mm, ev, hs;
        int p;
        @(negedge clk);
        rq = vote(r0, r1, r2);
        mm = disagree(r0, r1, r2);
        ev = mb && rq[mg];
        hs = ev && m_ready && !rst;
        check("m_grant",      m_grant,      mb ? (32'd1 << mg) : 32'd0);
        check("m_grant_idx",  m_grant_idx,  mb ? mg : 0);
        check("m_valid",      m_valid,      ev);
        check("s_ready",      s_ready,      hs ? (32'd1 << mg) : 32'd0);
        check("err_mismatch", err_mismatch, ms);
        check("err_count",    err_count,    mc);
        if (rst) begin
            model_reset();
        end else begin
            if (!mb) begin
                p = pick(rq, ml);
                if (p >= 0) begin mb = 1; mg = p; end
            end else if (hs) begin
                ml = mg;
                p = pick(rq & ~(S'(1) << mg), mg);
                if (p >= 0) mg = p; else begin mb = 0; mg = 0; end
            end else if (!rq[mg]) begin
                mb = 0; mg = 0;
            end
            if (err_clear) begin
                mc = mm ? 1 : 0; ms = mm;
            end else if (mm) begin
                mc = (mc == (1 << CW) - 1) ? mc : mc + 1; ms = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [S-1:0] rv, f1, f2;
        int sel;
        rst = 1'b1; m_ready = 1'b0; err_clear = 1'b0;
        set_req(4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();                                    // reset state
        rst = 1'b0;

        // alternating pair with master always ready
        set_req(4'b0101, 4'b0101, 4'b0101); m_ready = 1'b1;
        cycle(); check("tp_grant_c1", m_grant, 32'h1);
        cycle(); check("tp_grant_c2", m_grant, 32'h4);
        cycle(); check("tp_grant_c3", m_grant, 32'h1);
        repeat (3) cycle();
        set_req(4'b0000, 4'b0000, 4'b0000);
        repeat (2) cycle();

        // all request, master stalls 5 cycles then accepts once
        set_req(4'b1111, 4'b1111, 4'b1111); m_ready = 1'b0;
        repeat (6) cycle();
        m_ready = 1'b1; cycle();
        m_ready = 1'b0; repeat (2) cycle();
        set_req(4'b0000, 4'b0000, 4'b0000);
        repeat (2) cycle();

        // lone faulty replica on bit 2: no grant, three counted mismatches
        set_req(4'b0000, 4'b0100, 4'b0000);
        repeat (3) cycle();
        check("tp_err_count3", err_count, 32'd3);
        check("tp_err_sticky", err_mismatch, 32'd1);
        check("tp_no_grant2", m_grant, 32'd0);

        // continuous mismatch saturates
        repeat (20) cycle();
        check("tp_err_sat", err_count, 32'd15);

        // clear coinciding with mismatch, then clear alone
        err_clear = 1'b1; cycle();
        check("tp_clr_mm_cnt", err_count, 32'd1);
        check("tp_clr_mm_flag", err_mismatch, 32'd1);
        set_req(4'b0000, 4'b0000, 4'b0000); cycle();
        err_clear = 1'b0;
        check("tp_clr_cnt", err_count, 32'd0);
        cycle();

        // requester 3 granted then drops before the master accepts
        set_req(4'b1000, 4'b1000, 4'b1000); m_ready = 1'b0;
        repeat (3) cycle();
        set_req(4'b0000, 4'b0000, 4'b0000); repeat (2) cycle();
        set_req(4'b1111, 4'b1111, 4'b1111); m_ready = 1'b1;
        repeat (4) cycle();

        // reset while a grant is held
        m_ready = 1'b0; repeat (2) cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        check("tp_rst_grant", m_grant, 32'd0);
        check("tp_rst_valid", m_valid, 32'd0);
        check("tp_rst_count", err_count, 32'd0);
        set_req(4'b0000, 4'b0000, 4'b0000); cycle();

        // randomized traffic with occasional single and double replica faults
        for (int n = 0; n < 400; n++) begin
            rv = S'($urandom_range(0, 15));
            f1 = S'(1) << $urandom_range(0, S - 1);
            f2 = S'(1) << $urandom_range(0, S - 1);
            sel = $urandom_range(0, 15);
            set_req(rv, rv, rv);
            if (sel == 0) r1 = rv ^ f1;
            else if (sel == 1) r2 = rv ^ f1;
            else if (sel == 2) begin r0 = rv ^ f1; r2 = rv ^ f2; end
            m_ready   = ($urandom_range(0, 2) != 0);
            err_clear = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; err_clear = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
